// File: rtl/fetch_pc_unit_if.sv
// Fetch unit bus bundle: predictor, redirect, imem request/response and decode handshake.
// master is the fetch unit's view; slave is the surrounding pipeline/memory view.
interface fetch_pc_unit_if;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] bp_next_pc_i;
  logic        bp_taken_i;
  logic [31:0] pc_f_o;
  logic        pc_accept_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        fetch_valid_o;
  logic [31:0] fetch_instr_o;
  logic [31:0] fetch_pc_o;
  logic        fetch_pred_taken_o;
  logic        fetch_ready_i;

  modport master (
    input  redirect_i, redirect_pc_i, bp_next_pc_i, bp_taken_i,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, fetch_ready_i,
    output pc_f_o, pc_accept_o, imem_req_o, imem_addr_o,
    output fetch_valid_o, fetch_instr_o, fetch_pc_o, fetch_pred_taken_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, bp_next_pc_i, bp_taken_i,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, fetch_ready_i,
    input  pc_f_o, pc_accept_o, imem_req_o, imem_addr_o,
    input  fetch_valid_o, fetch_instr_o, fetch_pc_o, fetch_pred_taken_o
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch PC generator with in-order imem request tracking and a decode-facing fetch buffer.
// Redirects flush the buffer and count in-flight wrong-path responses to be discarded.
module fetch_pc_unit #(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned FIFO_DEPTH_W    = 2,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input logic             clk_i,
  input logic             rst_ni,
  fetch_pc_unit_if.master bus
);

  localparam int unsigned OutW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned TagPtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW    = FIFO_DEPTH_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
  } tag_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        taken;
  } entry_t;

  logic [31:0]       pc_q, pc_d;
  logic [OutW-1:0]   out_q, out_d;
  logic [OutW-1:0]   drop_q, drop_d;

  tag_t              tag_q [MAX_OUTSTANDING];
  tag_t              tag_d [MAX_OUTSTANDING];
  logic [TagPtrW-1:0] tag_wr_q, tag_wr_d;
  logic [TagPtrW-1:0] tag_rd_q, tag_rd_d;

  entry_t                 fifo_q [FIFO_DEPTH];
  entry_t                 fifo_d [FIFO_DEPTH];
  logic [FIFO_DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;

  logic   req;
  logic   accept;
  logic   rsp;
  logic   keep;
  logic   pop;
  logic   fifo_valid;
  tag_t   tag_head;
  entry_t fifo_head;

  function automatic logic [TagPtrW-1:0] tag_inc(input logic [TagPtrW-1:0] p);
    return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + TagPtrW'(1);
  endfunction

  // Credit rule: in-flight plus buffered never exceeds the buffer, so pushes always fit.
  always_comb begin
    req = rst_ni & ~bus.redirect_i &
          (32'(out_q) < MAX_OUTSTANDING) &
          ((32'(out_q) + 32'(count_q)) < FIFO_DEPTH);
    accept     = req & bus.imem_gnt_i;
    rsp        = bus.imem_rvalid_i & (out_q != '0);
    keep       = rsp & (drop_q == '0);
    fifo_valid = (count_q != '0);
    pop        = fifo_valid & bus.fetch_ready_i;
    tag_head   = tag_q[tag_rd_q];
    fifo_head  = fifo_q[rd_ptr_q];
  end

  // PC, outstanding count and wrong-path drop count.
  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q;
    drop_d = drop_q;

    if (bus.redirect_i) begin
      pc_d = bus.redirect_pc_i;
    end else if (accept) begin
      pc_d = bus.bp_next_pc_i;
    end

    unique case ({accept, rsp})
      2'b10:   out_d = out_q + OutW'(1);
      2'b01:   out_d = out_q - OutW'(1);
      default: out_d = out_q;
    endcase

    // Everything still in flight after this cycle's response belongs to the old path.
    if (bus.redirect_i) begin
      drop_d = out_q - OutW'(rsp);
    end else if (rsp && (drop_q != '0)) begin
      drop_d = drop_q - OutW'(1);
    end
  end

  // In-flight tag queue; kept through redirects so dropped responses still pop their tag.
  always_comb begin
    tag_d    = tag_q;
    tag_wr_d = tag_wr_q;
    tag_rd_d = tag_rd_q;
    if (accept) begin
      tag_d[tag_wr_q] = '{pc: pc_q, taken: bus.bp_taken_i};
      tag_wr_d        = tag_inc(tag_wr_q);
    end
    if (rsp) begin
      tag_rd_d = tag_inc(tag_rd_q);
    end
  end

  // Fetch buffer; a redirect clears it and wins over any same-cycle push or pop.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.redirect_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (keep) begin
        fifo_d[wr_ptr_q] = '{pc: tag_head.pc, instr: bus.imem_rdata_i, taken: tag_head.taken};
        wr_ptr_d         = wr_ptr_q + FIFO_DEPTH_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + FIFO_DEPTH_W'(1);
      end
      unique case ({keep, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q     <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      tag_q    <= '{default: '0};
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      fifo_q   <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      tag_q    <= tag_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign bus.pc_f_o             = pc_q;
  assign bus.imem_addr_o        = pc_q;
  assign bus.imem_req_o         = req;
  assign bus.pc_accept_o        = accept;
  assign bus.fetch_valid_o      = fifo_valid;
  assign bus.fetch_pc_o         = fifo_head.pc;
  assign bus.fetch_instr_o      = fifo_head.instr;
  assign bus.fetch_pred_taken_o = fifo_head.taken;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: imem model with configurable latency and a
// scoreboard of expected decode entries pushed at request accept, popped at decode handshake.
module tb_fetch_pc_unit;

  localparam logic [31:0] ResetPc = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        taken;
  } sb_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  fetch_pc_unit_if bus ();

  fetch_pc_unit dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  pend_t pend_q[$];
  sb_t   sb_q[$];

  logic [31:0] model_pc = ResetPc;
  int          cyc      = 0;
  int          lat      = 1;
  bit          rsp_en   = 1'b1;
  bit          drv_gnt  = 1'b0;
  bit          drv_ready = 1'b0;
  bit          drv_redirect = 1'b0;
  logic [31:0] drv_redirect_pc = '0;
  bit          jump_en  = 1'b0;
  logic [31:0] jump_from = '0;
  logic [31:0] jump_to   = '0;
  bit          arm_corner = 1'b0;
  bit          corner_hit = 1'b0;
  logic [31:0] corner_pc  = '0;
  int          accepts    = 0;
  int          pops       = 0;
  int          taken_pops = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'h1357_9BDF;
  endfunction

  // One clock cycle: drive at the negedge, observe 1ns later, update the model.
  task automatic cycle();
    bit          do_redir;
    bit          ready_now;
    logic [31:0] redir_pc;
    sb_t         e;
    @(negedge clk);
    cyc++;
    do_redir  = drv_redirect;
    ready_now = drv_ready;
    redir_pc  = drv_redirect_pc;
    if (arm_corner && pend_q.size() == 2 && rsp_en && pend_q[0].due <= cyc &&
        bus.fetch_valid_o) begin
      do_redir   = 1'b1;
      ready_now  = 1'b1;
      redir_pc   = corner_pc;
      arm_corner = 1'b0;
      corner_hit = 1'b1;
    end
    bus.redirect_i    = do_redir;
    bus.redirect_pc_i = redir_pc;
    bus.imem_gnt_i    = drv_gnt;
    bus.fetch_ready_i = ready_now;
    if (jump_en && model_pc == jump_from) begin
      bus.bp_next_pc_i = jump_to;
      bus.bp_taken_i   = 1'b1;
    end else begin
      bus.bp_next_pc_i = model_pc + 32'd4;
      bus.bp_taken_i   = 1'b0;
    end
    if (rsp_en && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = instr_of(pend_q[0].pc);
      void'(pend_q.pop_front());
    end else begin
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = '0;
    end
    #1;
    if (bus.fetch_valid_o && ready_now && !do_redir) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_entry: got pc=%h with nothing expected", bus.fetch_pc_o);
      end else begin
        e = sb_q.pop_front();
        if (bus.fetch_pc_o !== e.pc || bus.fetch_instr_o !== e.instr ||
            bus.fetch_pred_taken_o !== e.taken) begin
          errors++;
          $display("FAIL fetch_entry: got pc=%h instr=%h taken=%b, expected pc=%h instr=%h taken=%b",
                   bus.fetch_pc_o, bus.fetch_instr_o, bus.fetch_pred_taken_o,
                   e.pc, e.instr, e.taken);
        end
      end
      pops++;
      if (bus.fetch_pred_taken_o === 1'b1) taken_pops++;
    end
    if (do_redir) begin
      checks++;
      if (bus.imem_req_o !== 1'b0) begin
        errors++;
        $display("FAIL req_in_redirect: got %b, expected 0", bus.imem_req_o);
      end
    end
    if (!drv_gnt) begin
      checks++;
      if (bus.pc_accept_o !== 1'b0) begin
        errors++;
        $display("FAIL accept_without_gnt: got %b, expected 0", bus.pc_accept_o);
      end
    end
    if (bus.imem_req_o === 1'b1 && drv_gnt) begin
      checks++;
      if (bus.imem_addr_o !== model_pc || bus.pc_f_o !== model_pc || bus.pc_accept_o !== 1'b1) begin
        errors++;
        $display("FAIL fetch_addr: got addr=%h pc_f=%h accept=%b, expected addr=%h accept=1",
                 bus.imem_addr_o, bus.pc_f_o, bus.pc_accept_o, model_pc);
      end
      pend_q.push_back('{pc: model_pc, due: cyc + lat});
      sb_q.push_back('{pc: model_pc, instr: instr_of(model_pc), taken: bus.bp_taken_i});
      model_pc = bus.bp_next_pc_i;
      accepts++;
    end
    if (do_redir) begin
      sb_q.delete();
      model_pc = redir_pc;
    end
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    drv_gnt   = 1'b0;
    drv_ready = 1'b1;
    rsp_en    = 1'b1;
    while ((sb_q.size() != 0 || pend_q.size() != 0) && n < max_cycles) begin
      cycle();
      n++;
    end
    checks++;
    if (sb_q.size() != 0 || pend_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d entries and %0d responses left, expected 0",
               sb_q.size(), pend_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n             = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.bp_next_pc_i  = '0;
    bus.bp_taken_i    = 1'b0;
    bus.imem_gnt_i    = 1'b1;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;
    bus.fetch_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks += 3;
    if (bus.fetch_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b, expected 0", bus.fetch_valid_o);
    end
    if (bus.imem_req_o !== 1'b0) begin
      errors++; $display("FAIL reset_req: got %b, expected 0", bus.imem_req_o);
    end
    if (bus.pc_accept_o !== 1'b0) begin
      errors++; $display("FAIL reset_accept: got %b, expected 0", bus.pc_accept_o);
    end
    @(negedge clk);
    bus.imem_gnt_i = 1'b0;
    rst_n          = 1'b1;
    #1;
    checks += 2;
    if (bus.imem_req_o !== 1'b1) begin
      errors++; $display("FAIL req_after_release: got %b, expected 1", bus.imem_req_o);
    end
    if (bus.imem_addr_o !== ResetPc) begin
      errors++; $display("FAIL reset_pc: got %h, expected %h", bus.imem_addr_o, ResetPc);
    end
  endtask

  task automatic test_backpressure();
    int a0;
    int p0;
    lat       = 1;
    drv_gnt   = 1'b1;
    drv_ready = 1'b0;
    a0        = accepts;
    repeat (10) cycle();
    checks += 3;
    if (accepts - a0 != 4) begin
      errors++; $display("FAIL bp_accepts: got %0d, expected 4", accepts - a0);
    end
    if (bus.imem_req_o !== 1'b0) begin
      errors++; $display("FAIL bp_req_low: got %b, expected 0", bus.imem_req_o);
    end
    if (bus.fetch_valid_o !== 1'b1) begin
      errors++; $display("FAIL bp_valid: got %b, expected 1", bus.fetch_valid_o);
    end
    p0 = pops;
    drain(20);
    checks++;
    if (pops - p0 != 4) begin
      errors++; $display("FAIL bp_drained: got %0d entries, expected 4", pops - p0);
    end
  endtask

  task automatic test_streaming();
    int p0;
    lat       = 1;
    drv_ready = 1'b1;
    drv_gnt   = 1'b1;
    cycle();
    checks++;
    if (bus.fetch_valid_o !== 1'b0) begin
      errors++; $display("FAIL lat_gnt_cycle: got %b, expected 0", bus.fetch_valid_o);
    end
    cycle();
    checks++;
    if (bus.fetch_valid_o !== 1'b0) begin
      errors++; $display("FAIL lat_rvalid_cycle: got %b, expected 0", bus.fetch_valid_o);
    end
    cycle();
    checks++;
    if (bus.fetch_valid_o !== 1'b1) begin
      errors++; $display("FAIL lat_gnt_plus_2: got %b, expected 1", bus.fetch_valid_o);
    end
    repeat (5) cycle();
    p0 = pops;
    repeat (10) cycle();
    checks++;
    if (pops - p0 != 10) begin
      errors++; $display("FAIL stream_rate: got %0d entries in 10 cycles, expected 10", pops - p0);
    end
    drain(20);
  endtask

  task automatic test_pred_taken();
    int t0;
    drv_ready       = 1'b1;
    drv_gnt         = 1'b1;
    drv_redirect    = 1'b1;
    drv_redirect_pc = 32'h0000_0008;
    cycle();
    drv_redirect = 1'b0;
    jump_en      = 1'b1;
    jump_from    = 32'h0000_0010;
    jump_to      = 32'h0000_0200;
    t0           = taken_pops;
    repeat (8) cycle();
    jump_en = 1'b0;
    drain(30);
    checks++;
    if (taken_pops - t0 != 1) begin
      errors++; $display("FAIL pred_taken_count: got %0d, expected 1", taken_pops - t0);
    end
  endtask

  task automatic test_redirect();
    lat       = 1;
    drv_ready = 1'b0;
    drv_gnt   = 1'b1;
    rsp_en = 1'b1; cycle();
    rsp_en = 1'b0; cycle();
    rsp_en = 1'b1; cycle();
    rsp_en = 1'b0; cycle();
    checks++;
    if (bus.fetch_valid_o !== 1'b1) begin
      errors++; $display("FAIL redir_setup_valid: got %b, expected 1", bus.fetch_valid_o);
    end
    drv_redirect    = 1'b1;
    drv_redirect_pc = 32'h0000_0100;
    cycle();
    drv_redirect = 1'b0;
    cycle();
    checks++;
    if (bus.fetch_valid_o !== 1'b0) begin
      errors++; $display("FAIL redir_flush: got %b, expected 0", bus.fetch_valid_o);
    end
    rsp_en    = 1'b1;
    drv_ready = 1'b1;
    repeat (12) cycle();
    drain(30);
  endtask

  task automatic test_redirect_corner();
    int n = 0;
    lat        = 2;
    drv_ready  = 1'b0;
    drv_gnt    = 1'b1;
    corner_hit = 1'b0;
    corner_pc  = 32'h0000_0300;
    arm_corner = 1'b1;
    while (arm_corner && n < 20) begin
      cycle();
      n++;
    end
    arm_corner = 1'b0;
    checks++;
    if (!corner_hit) begin
      errors++; $display("FAIL corner_reached: got 0, expected 1");
    end
    cycle();
    checks++;
    if (bus.fetch_valid_o !== 1'b0) begin
      errors++; $display("FAIL corner_flush: got %b, expected 0", bus.fetch_valid_o);
    end
    drv_ready = 1'b1;
    repeat (10) cycle();
    drain(30);
    lat = 1;
  endtask

  task automatic test_reset_midstream();
    int n = 0;
    int a0;
    lat       = 2;
    drv_ready = 1'b0;
    drv_gnt   = 1'b1;
    while (!(pend_q.size() == 2 && bus.fetch_valid_o === 1'b1) && n < 20) begin
      cycle();
      n++;
    end
    checks++;
    if (pend_q.size() != 2) begin
      errors++; $display("FAIL midrst_setup: got %0d outstanding, expected 2", pend_q.size());
    end
    @(negedge clk);
    rst_n             = 1'b0;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.redirect_i    = 1'b0;
    #1;
    checks += 2;
    if (bus.fetch_valid_o !== 1'b0) begin
      errors++; $display("FAIL midrst_valid: got %b, expected 0", bus.fetch_valid_o);
    end
    if (bus.imem_req_o !== 1'b0) begin
      errors++; $display("FAIL midrst_req: got %b, expected 0", bus.imem_req_o);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    sb_q.delete();
    model_pc = ResetPc;
    drv_gnt  = 1'b0;
    bus.imem_gnt_i = 1'b0;
    #1;
    checks++;
    if (bus.imem_addr_o !== ResetPc) begin
      errors++; $display("FAIL midrst_pc: got %h, expected %h", bus.imem_addr_o, ResetPc);
    end
    rsp_en = 1'b1;
    repeat (3) cycle();
    checks++;
    if (bus.fetch_valid_o !== 1'b0) begin
      errors++; $display("FAIL stray_ignored: got %b, expected 0", bus.fetch_valid_o);
    end
    pend_q.delete();
    lat       = 1;
    drv_gnt   = 1'b1;
    drv_ready = 1'b1;
    a0        = accepts;
    repeat (10) cycle();
    checks++;
    if (accepts - a0 < 8) begin
      errors++; $display("FAIL midrst_resume: got %0d accepts, expected at least 8", accepts - a0);
    end
    drain(20);
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_streaming();
    test_pred_taken();
    test_redirect();
    test_redirect_corner();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
